// File: rtl/mul_seq.sv
// mul_seq: iterative RV64M multiply sequencer (MUL/MULH/MULHSU/MULHU/MULW)
// with a one-entry product cache for back-to-back ops on the same operands.
module mul_seq #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd
);

  localparam int PW    = 2 * XLEN;
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int NFULL = XLEN / BPC;
  localparam int NWORD = 32 / BPC;
  localparam int CW    = $clog2(NFULL + 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   n_q;
  logic            neg_q;
  logic            word_q;
  logic            hit_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  logic            out_valid_q;
  logic [XLEN-1:0] out_data_q;
  logic [4:0]      out_rd_q;

  logic            ent_vld_q;
  logic [XLEN-1:0] ent_rs1_q;
  logic [XLEN-1:0] ent_rs2_q;
  logic [1:0]      ent_op_q;
  logic [PW-1:0]   ent_prod_q;

  logic            accept;
  logic            hit;
  logic            s1;
  logic            s2;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] hit_hi;
  logic [BPC-1:0]  chunk;
  logic [PW-1:0]   pp_d;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   prod_d;
  logic [XLEN-1:0] res_d;
  logic [CW-1:0]   n_d;

  // Amount by which a signed-view high word sits below the unsigned one.
  function automatic logic [XLEN-1:0] corr(
    input logic [1:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] c;
    c = '0;
    if ((op == OP_MULH || op == OP_MULHSU) && a[XLEN-1])
      c = c + b;
    if (op == OP_MULH && b[XLEN-1])
      c = c + a;
    return c;
  endfunction

  always_comb begin
    in_ready = ((state_q == IDLE) ||
                (state_q == DONE && out_ready)) && !flush;
    accept   = in_valid && in_ready;

    s1    = !in_word && (in_op == OP_MULH || in_op == OP_MULHSU);
    s2    = !in_word && (in_op == OP_MULH);
    a_neg = s1 && in_rs1[XLEN-1];
    b_neg = s2 && in_rs2[XLEN-1];
    a_mag = a_neg ? -in_rs1 : in_rs1;
    b_mag = b_neg ? -in_rs2 : in_rs2;
    if (in_word) begin
      a_mag = {{(XLEN-32){1'b0}}, in_rs1[31:0]};
      b_mag = {{(XLEN-32){1'b0}}, in_rs2[31:0]};
    end
    n_d = in_word ? CW'(NWORD) : CW'(NFULL);

    hit = ent_vld_q && !in_word &&
          in_rs1 == ent_rs1_q && in_rs2 == ent_rs2_q &&
          (in_op == ent_op_q || in_op == OP_MUL ||
           ent_op_q == OP_MUL);
    hit_hi = ent_prod_q[PW-1:XLEN]
           + corr(ent_op_q, in_rs1, in_rs2)
           - corr(in_op, in_rs1, in_rs2);

    chunk = mplier_q[BPC-1:0];
    pp_d  = '0;
    for (int i = 0; i < BPC; i++)
      if (chunk[i])
        pp_d = pp_d + (mcand_q << i);
    acc_d = acc_q + pp_d;

    prod_d = neg_q ? -acc_q : acc_q;
    priority case (1'b1)
      word_q:
        res_d = {{(XLEN-32){prod_d[31]}}, prod_d[31:0]};
      (op_q == OP_MUL):
        res_d = prod_d[XLEN-1:0];
      default:
        res_d = prod_d[PW-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      neg_q       <= 1'b0;
      word_q      <= 1'b0;
      hit_q       <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      ent_vld_q   <= 1'b0;
      ent_rs1_q   <= '0;
      ent_rs2_q   <= '0;
      ent_op_q    <= '0;
      ent_prod_q  <= '0;
    end else begin
      if (flush)
        ent_vld_q <= 1'b0;
      if (flush && state_q != IDLE) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (cnt_q == n_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= res_d;
              out_rd_q    <= rd_q;
              // Only freshly computed full-width products refill the cache
              if (!word_q && !hit_q) begin
                ent_vld_q  <= 1'b1;
                ent_rs1_q  <= rs1_q;
                ent_rs2_q  <= rs2_q;
                ent_op_q   <= op_q;
                ent_prod_q <= prod_d;
              end
            end else begin
              acc_q    <= acc_d;
              mcand_q  <= mcand_q << BPC;
              mplier_q <= mplier_q >> BPC;
              cnt_q    <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            if (out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
          end
        endcase
        if (accept) begin
          state_q  <= RUN;
          acc_q    <= hit ? {hit_hi, ent_prod_q[XLEN-1:0]} : '0;
          mcand_q  <= {{XLEN{1'b0}}, a_mag};
          mplier_q <= b_mag;
          cnt_q    <= '0;
          n_q      <= hit ? '0 : n_d;
          neg_q    <= hit ? 1'b0 : (a_neg ^ b_neg);
          word_q   <= in_word;
          hit_q    <= hit;
          op_q     <= in_op;
          rd_q     <= in_rd;
          rs1_q    <= in_rs1;
          rs2_q    <= in_rs2;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vector table plus hand-written sequences for
// backpressure, flush and mid-operation reset of mul_seq.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_word;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  int errs   = 0;
  int checks = 0;

  localparam logic [63:0] A   = 64'hFF22334455667788;
  localparam logic [63:0] B   = 64'h00000000AABB0077;
  localparam logic [63:0] MIN = 64'h8000000000000000;
  localparam logic [63:0] M1  = 64'hFFFFFFFFFFFFFFFF;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd)
  );

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_word  = v.word;
    in_rs1   = v.a;
    in_rs2   = v.b;
    in_rd    = v.rd;
    #1;
    for (int n = 0; n < 50 && !in_ready; n++)
      tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    out_ready = 1'b1;
    issue(v);
    wait_out(cyc);
    chk({tag, " data"}, out_data, v.exp);
    chk({tag, " rd"}, 64'(out_rd), 64'(v.rd));
    chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
    tick();
  endtask

  task automatic no_result(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid)
        seen++;
      tick();
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    vec_t v;

    vecs.push_back('{2'b00, 1'b0, A,   B,   5'd1,  64'h6C8641FD52F99038, 9});
    vecs.push_back('{2'b01, 1'b0, A,   B,   5'd2,  64'hFFFFFFFFFF6C1406, 1});
    vecs.push_back('{2'b11, 1'b0, A,   B,   5'd3,  64'h00000000AA27147D, 1});
    vecs.push_back('{2'b10, 1'b0, A,   B,   5'd4,  64'hFFFFFFFFFF6C1406, 1});
    vecs.push_back('{2'b01, 1'b1, A,   B,   5'd5,  64'h0000000052F99038, 5});
    vecs.push_back('{2'b00, 1'b1, A,   64'h87654321,
                     5'd6, 64'hFFFFFFFFB4260088, 5});
    vecs.push_back('{2'b01, 1'b0, A,   A,   5'd7,  64'h0000C02B1FC02E8C, 9});
    vecs.push_back('{2'b11, 1'b0, A,   A,   5'd8,  64'hFE4526B3CA8D1D9C, 9});
    vecs.push_back('{2'b00, 1'b0, 64'd0, A, 5'd9,  64'h0, 9});
    vecs.push_back('{2'b01, 1'b0, MIN, MIN, 5'd10, 64'h4000000000000000, 9});
    vecs.push_back('{2'b00, 1'b0, MIN, MIN, 5'd11, 64'h0, 1});
    vecs.push_back('{2'b11, 1'b0, MIN, MIN, 5'd12, 64'h4000000000000000, 9});
    vecs.push_back('{2'b10, 1'b0, M1,  M1,  5'd13, 64'hFFFFFFFFFFFFFFFF, 9});
    vecs.push_back('{2'b00, 1'b0, M1,  M1,  5'd14, 64'h1, 1});
    vecs.push_back('{2'b11, 1'b0, M1,  M1,  5'd15, 64'hFFFFFFFFFFFFFFFE, 9});
    vecs.push_back('{2'b01, 1'b0, M1,  M1,  5'd16, 64'h0, 9});

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_word   = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset out_rd", 64'(out_rd), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    v = '{2'b00, 1'b1, A, B, 5'd20, 64'h0000000052F99038, 5};
    issue(v);
    wait_out(cyc);
    chk("hold latency", 64'(cyc), 64'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold out_data", out_data, 64'h0000000052F99038);
      chk("hold out_rd", 64'(out_rd), 64'd20);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_word   = 1'b1;
    in_rs1    = A;
    in_rs2    = 64'h87654321;
    in_rd     = 5'd21;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b out_valid drop", 64'(out_valid), 64'd0);
    wait_out(cyc);
    chk("b2b latency", 64'(cyc), 64'd5);
    chk("b2b data", out_data, 64'hFFFFFFFFB4260088);
    chk("b2b rd", 64'(out_rd), 64'd21);
    tick();

    // Flush in RUN cycle 3 kills the op and invalidates the cache.
    run_vec('{2'b00, 1'b0, A, B, 5'd22, 64'h6C8641FD52F99038, 9}, "pre-flush");
    issue('{2'b00, 1'b0, 64'h1234, 64'h5678, 5'd23, 64'h0, 9});
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush idle in_ready", 64'(in_ready), 64'd1);
    no_result("flush no result");
    run_vec('{2'b00, 1'b0, A, B, 5'd24, 64'h6C8641FD52F99038, 9}, "post-flush");

    // flush beats in_valid: no accept.
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_word  = 1'b0;
    in_rs1   = A;
    in_rs2   = B;
    in_rd    = 5'd25;
    flush    = 1'b1;
    #1;
    chk("flush blocks in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("flush idle again", 64'(in_ready), 64'd1);
    no_result("flush no accept");

    // Reset in the middle of RUN discards everything.
    issue('{2'b00, 1'b0, A, B, 5'd26, 64'h0, 9});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid-reset out_valid", 64'(out_valid), 64'd0);
    chk("mid-reset out_data", out_data, 64'd0);
    chk("mid-reset out_rd", 64'(out_rd), 64'd0);
    chk("mid-reset in_ready", 64'(in_ready), 64'd1);
    no_result("mid-reset no result");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle sequencer for the RV64M multiply datapath: MUL, MULH, MULHSU, MULHU and MULW.
- Accepts one operation at a time from the execute stage over a valid/ready handshake.
- Runs an iterative shift-add over BITS_PER_CYCLE multiplier bits per cycle, then returns a 64-bit writeback value tagged with the destination register.
- Keeps the last full 128-bit product, so a repeated multiply with the same operands (e.g. MULH right after MUL) finishes in one cycle.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- BITS_PER_CYCLE, 8, multiplier bits consumed per RUN cycle; must divide 32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_word  in  1  1 = MULW; in_op is ignored
- in_rs1  in  64  multiplicand
- in_rs2  in  64  multiplier
- in_rd  in  5  destination tag
- flush  in  1  abort the in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  64  writeback value
- out_rd  out  5  destination tag of the result

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0, out_data=0, out_rd=0; reuse entry invalid. Reset mid-operation discards all work.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready), and is 0 while flush=1. Accept = in_valid & in_ready.
- Operand preparation on accept:
  - rs1 is signed for MULH and MULHSU.
  - rs2 is signed for MULH only.
  - The magnitudes are latched; neg = sign(rs1_eff) XOR sign(rs2_eff).
  - Word op: only bits [31:0] are used, both treated as unsigned.
- RUN: each cycle, acc += mcand * chunk << shift, where chunk is the next BITS_PER_CYCLE bits of the multiplier, LSB first. acc is 128 bits.
  - Iteration count N = 64/BITS_PER_CYCLE (word: 32/BITS_PER_CYCLE).
  - After the Nth iteration, go to DONE.
- DONE: product = neg ? -acc : acc (128-bit two's complement).
  - MUL returns product[63:0].
  - MULH* returns product[127:64].
  - MULW returns the sign-extension of product[31:0].
  - out_valid is held, with out_data and out_rd stable, until out_ready.
  - On handshake with no new accept: IDLE, out_valid=0 next cycle.
  - Handshake plus accept in the same cycle: go to RUN (or DONE on a reuse hit).
- Latency: accept on edge 0; out_valid is first high after edge N+1 (BITS_PER_CYCLE=8: 9 cycles for 64-bit, 5 for word).
- Reuse entry: stores rs1, rs2, op and the signed 128-bit product of the last completed non-word op.
  - Hit when a new non-word request has the same rs1 and rs2, and either the same op or one of the two is MUL (the low 64 bits are signedness-independent).
  - On a hit, skip RUN and assert out_valid after edge 1.
  - A word op never hits and never updates the entry.
  - The entry is invalidated by flush and by reset.
- flush: from RUN or DONE, go to IDLE next cycle with out_valid=0 and no handshake consumed. flush beats in_valid in the same cycle (no accept). flush in IDLE has no effect except entry invalidation.
- Boundary cases:
  - Operand 0 gives 0 after the full latency; there is no early termination.
  - The most negative × most negative case under MULH gives 0x4000000000000000.
  - out_ready held low keeps DONE indefinitely.

Test Plan:
- MUL, rs1=0xFF22334455667788, rs2=0x00000000AABB0077, out_ready=1 -> out_data=0x6C8641FD52F99038, out_valid after 9 cycles, out_rd echoed.
- The same operands with MULH -> 0xFFFFFFFFFF6C1406; MULHU -> 0x00000000AA27147D; MULHSU -> 0xFFFFFFFFFF6C1406. Each is a reuse hit on the previous entry and takes 1 cycle.
- MULW on the same pair -> 0x0000000052F99038; MULW with rs2=0x87654321 -> 0xFFFFFFFFB4260088; both take 5 cycles.
- MULH with rs1=rs2=0xFF22334455667788 -> 0x0000C02B1FC02E8C; then MULHU with the same operands -> miss, full 9-cycle latency, unsigned high word.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. Then release out_ready with a new in_valid in the same cycle -> back-to-back accept with no idle cycle.
- Assert flush in RUN cycle 3 -> no out_valid, IDLE next cycle; repeat the previous operands -> miss (entry invalidated). Assert rst mid-RUN -> all outputs zero.
